// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared state encoding, register map and CTRL field layout for timer_dev
package timer_dev_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  localparam logic [1:0] CTRL_OFS = 2'd0, PRESET_OFS = 2'd1, COUNT_OFS = 2'd2;
  localparam int EN_BIT = 0, MODE_LSB = 1, MODE_MSB = 2, IM_BIT = 3;
  localparam logic [1:0] MODE_ONESHOT = 2'b00, MODE_RELOAD = 2'b01;
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00, TIMER1_BASE = 32'h0000_7F10;
endpackage

// File: rtl/timer_dev.sv
// timer_dev: bus-mapped down-counter raising IRQ at zero; TIMER_DEV_AUTORELOAD_EN enables auto-reload mode
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Sel,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);
  state_t state, state_n;
  logic [3:0] ctrl, ctrl_n;
  logic [31:0] preset, preset_n, count, count_n;
  logic irq_flag, flag_n, wr, en;
  assign wr = Sel & WE;
  assign en = ctrl[EN_BIT];
  // bus writes are applied after the FSM so they override it on the same edge
  always_comb begin
    state_n = state;
    ctrl_n = ctrl;
    preset_n = preset;
    count_n = count;
    flag_n = irq_flag;
    case (state)
      IDLE: state_n = en ? LOAD : IDLE;
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: begin
        if (!en) state_n = IDLE;
        else if (count == '0) begin
          state_n = INT;
          flag_n = 1'b1;
        end else count_n = count - 32'd1;
      end
      default: begin
`ifdef TIMER_DEV_AUTORELOAD_EN
        if (ctrl[MODE_MSB:MODE_LSB] == MODE_RELOAD) begin
          flag_n = 1'b0;
          state_n = LOAD;
        end else begin
          ctrl_n[EN_BIT] = 1'b0;
          state_n = IDLE;
        end
`else
        ctrl_n[EN_BIT] = 1'b0;
        state_n = IDLE;
`endif
      end
    endcase
    if (wr && Addr == CTRL_OFS) ctrl_n = DIn[IM_BIT:0];
    if (wr && Addr == PRESET_OFS) preset_n = DIn;
    if (wr && (Addr == CTRL_OFS || Addr == PRESET_OFS)) flag_n = 1'b0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      irq_flag <= 1'b0;
      IRQ <= 1'b0;
    end else begin
      state <= state_n;
      ctrl <= ctrl_n;
      preset <= preset_n;
      count <= count_n;
      irq_flag <= flag_n;
      IRQ <= ctrl_n[IM_BIT] & flag_n;
    end
  end
  always_comb
    DOut = Addr == CTRL_OFS   ? {28'd0, ctrl} :
           Addr == PRESET_OFS ? preset :
           Addr == COUNT_OFS  ? count : '0;
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed and randomized checks of timer_dev against an arithmetic timeline model
module tb_timer_dev;
  import timer_dev_pkg::*;
  logic clk = 0, reset = 1, Sel = 0, WE = 0, IRQ;
  logic [1:0] Addr = 0;
  logic [31:0] DIn = 0, DOut;
  int total = 0, bad = 0;

  timer_dev dut (.clk(clk), .reset(reset), .Sel(Sel), .Addr(Addr), .WE(WE), .DIn(DIn), .DOut(DOut), .IRQ(IRQ));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1 d = DOut;
  endtask

  task automatic bus(input logic s, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Sel = s; WE = 1; Addr = a; DIn = d;
    @(posedge clk);
    #1 Sel = 0; WE = 0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // COUNT seen after edge k when enabled at edge 0 with PRESET n, starting from c0
  function automatic logic [31:0] mcount(int n, int k, logic [31:0] c0);
    return k < 2 ? c0 : (k - 2 >= n ? 32'd0 : 32'(n - (k - 2)));
  endfunction

  task automatic oneshot(input int n, input logic im);
    logic [31:0] d, c0;
    rd(COUNT_OFS, c0);
    bus(1, PRESET_OFS, 32'(n));
    bus(1, CTRL_OFS, {28'd0, im, 3'b001});
    for (int k = 1; k <= n + 6; k++) begin
      step;
      rd(COUNT_OFS, d); chk("os_count", d, mcount(n, k, c0));
      chk("os_irq", IRQ, im && k >= n + 3);
      rd(CTRL_OFS, d); chk("os_ctrl", d, k >= n + 4 ? {im, 3'b000} : {im, 3'b001});
    end
  endtask

  initial begin
    logic [31:0] d, c0;
    logic found;
    int n, rises, highs, t1, t2;
    logic prev;
    #1 reset = 0;
    #1;
    for (int a = 0; a < 4; a++) begin rd(2'(a), d); chk("rst_dout", d, 0); end
    chk("rst_irq", IRQ, 0);
    @(negedge clk) reset = 1;
    step;

    oneshot(5, 1);
    for (int i = 0; i < 3; i++) begin step; chk("os_irq_held", IRQ, 1); end
    bus(1, CTRL_OFS, 32'h8);
    chk("os_irq_cleared", IRQ, 0);
    oneshot(0, 1);
    oneshot($urandom_range(1, 9), 1);

    n = $urandom_range(1, 6);
    oneshot(n, 0);
    bus(1, CTRL_OFS, 32'h9);
    chk("mask_flag_clr", IRQ, 0);
    step; step;
    rd(COUNT_OFS, d); chk("mask_restart", d, 32'(n));
    chk("mask_irq", IRQ, 0);
    for (int k = 3; k <= n + 4; k++) step;
    chk("mask_reexpire_irq", IRQ, 1);

    bus(1, PRESET_OFS, 100);
    bus(1, CTRL_OFS, 32'h9);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin step; rd(COUNT_OFS, d); found = d == 60; end
    chk("dis_reach60", found, 1);
    bus(1, CTRL_OFS, 32'h8);
    for (int i = 0; i < 8; i++) begin
      step;
      rd(COUNT_OFS, d); chk("dis_frozen", d, 59);
      chk("dis_irq", IRQ, 0);
    end
    bus(1, CTRL_OFS, 32'h9);
    step; step;
    rd(COUNT_OFS, d); chk("dis_reload", d, 100);
    bus(1, CTRL_OFS, 32'h0);
    step;

    rd(COUNT_OFS, c0);
    bus(1, PRESET_OFS, 20);
    bus(1, CTRL_OFS, 32'h9);
    for (int k = 1; k <= 4; k++) step;
    bus(1, PRESET_OFS, 7);
    rd(COUNT_OFS, d); chk("col_preset_cnt", d, mcount(20, 5, c0));
    rd(PRESET_OFS, d); chk("col_preset_rd", d, 7);
    bus(1, COUNT_OFS, 32'h55);
    rd(COUNT_OFS, d); chk("col_count_wr", d, mcount(20, 6, c0));
    bus(0, CTRL_OFS, 32'h0);
    rd(CTRL_OFS, d); chk("col_nosel_ctrl", d, 32'h9);
    rd(COUNT_OFS, d); chk("col_nosel_cnt", d, mcount(20, 7, c0));
    bus(0, PRESET_OFS, 32'h3);
    rd(PRESET_OFS, d); chk("col_nosel_preset", d, 7);
    bus(1, 2'd3, 32'hFFFF_FFFF);
    rd(2'd3, d); chk("col_addr3", d, 0);
    for (int k = 10; k <= 25; k++) begin
      step;
      rd(COUNT_OFS, d); chk("col_count", d, mcount(20, k, c0));
      chk("col_irq", IRQ, k >= 23);
    end

    bus(1, PRESET_OFS, 2);
    bus(1, CTRL_OFS, 32'hB);
    rises = 0; highs = 0; prev = 0;
    for (int k = 1; k <= 20; k++) begin
      step;
      if (IRQ && !prev) rises++;
      if (IRQ) highs++;
`ifdef TIMER_DEV_AUTORELOAD_EN
      chk("ar_irq", IRQ, k % 5 == 0);
`endif
      prev = IRQ;
    end
`ifdef TIMER_DEV_AUTORELOAD_EN
    chk("ar_rises", rises, 4);
    chk("ar_highs", highs, 4);
    bus(1, PRESET_OFS, 7);
    t1 = 0; t2 = 0;
    for (int k = 22; k <= 45 && t2 == 0; k++) begin
      step;
      if (IRQ && t1 == 0) t1 = k;
      else if (IRQ) t2 = k;
    end
    chk("ar_first_new", t1, 30);
    chk("ar_period10", t2 - t1, 10);
`else
    chk("os_only_rises", rises, 1);
    chk("os_only_highs", highs, 16);
    rd(CTRL_OFS, d); chk("os_only_ctrl", d, 32'hA);
`endif
    bus(1, CTRL_OFS, 32'h0);
    step; step;

    bus(1, PRESET_OFS, 50);
    bus(1, CTRL_OFS, 32'h9);
    for (int i = 0; i < 10; i++) step;
    #1 reset = 0;
    for (int a = 0; a < 3; a++) begin rd(2'(a), d); chk("rst_mid_dout", d, 0); end
    chk("rst_mid_irq", IRQ, 0);
    @(negedge clk) reset = 1;
    bus(1, PRESET_OFS, 3);
    bus(1, CTRL_OFS, 32'h9);
    for (int i = 0; i < 6; i++) step;
    chk("rst_pre_irq", IRQ, 1);
    #1 reset = 0;
    #1 chk("rst_irq_async", IRQ, 0);
    rd(PRESET_OFS, d); chk("rst_preset", d, 0);
    rd(CTRL_OFS, d); chk("rst_ctrl", d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
